// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory bus between the fetch and load/store ports.
// Grant in IDLE, bus request 1 cycle later and held until mem_req_ready; completion is combinational with mem_resp_valid.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_ready,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wmask,
  output logic                data_ack,
  output logic [DATA_W-1:0]   data_rdata,
  input  logic                flush,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                timeout
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0] TMO = (CNT_W + 1)'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } bus_req_t;

  state_t     state_q, state_d;
  owner_t     owner_q, owner_d;
  owner_t     conflict_last_q, conflict_last_d;
  logic       kill_q, kill_d;
  logic       timeout_q, timeout_d;
  logic       mem_req_valid_q, mem_req_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  bus_req_t   req_q, req_d;
  logic       inst_elig, grant_vld, grant_data, completion, expire;

  always_comb begin
    inst_elig  = inst_req && !flush;
    grant_vld  = inst_elig || data_req;
    grant_data = data_req && (!inst_elig || conflict_last_q != OWN_DATA);
    completion = (state_q == RESP) && mem_resp_valid;
    cnt_inc    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    // A completion landing on the expiry cycle takes priority over the abort.
    expire     = (TIMEOUT != 0) && (state_q != IDLE) && (cnt_inc == TMO) && !completion;

    state_d         = state_q;
    owner_d         = owner_q;
    conflict_last_d = conflict_last_q;
    kill_d          = kill_q;
    timeout_d       = timeout_q;
    cnt_d           = cnt_q;
    req_d           = req_q;
    inst_ready      = 1'b0;
    data_ack        = 1'b0;

    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (grant_vld) begin
          state_d = REQ;
          cnt_d   = '0;
          owner_d = grant_data ? OWN_DATA : OWN_INST;
          if (inst_elig && data_req) conflict_last_d = owner_d;
          if (grant_data) begin
            req_d.we    = data_we;
            req_d.addr  = data_addr;
            req_d.wdata = data_wdata;
            req_d.wmask = data_we ? data_wmask : '0;
          end else begin
            req_d.we    = 1'b0;
            req_d.addr  = inst_addr;
            req_d.wdata = '0;
            req_d.wmask = '0;
          end
        end
      end
      REQ, RESP: begin
        cnt_d = cnt_inc[CNT_W-1:0];
        if (flush && owner_q == OWN_INST) kill_d = 1'b1;
        if (state_q == REQ && mem_req_ready) state_d = RESP;
        if (completion) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          if (owner_q == OWN_DATA) data_ack = 1'b1;
          else                     inst_ready = !kill_q && !flush;
        end else if (expire) begin
          state_d   = IDLE;
          kill_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    mem_req_valid_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      owner_q         <= OWN_INST;
      conflict_last_q <= OWN_INST;
      kill_q          <= 1'b0;
      timeout_q       <= 1'b0;
      mem_req_valid_q <= 1'b0;
      cnt_q           <= '0;
      req_q           <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      conflict_last_q <= conflict_last_d;
      kill_q          <= kill_d;
      timeout_q       <= timeout_d;
      mem_req_valid_q <= mem_req_valid_d;
      cnt_q           <= cnt_d;
      req_q           <= req_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = req_q.we;
  assign mem_addr      = req_q.addr;
  assign mem_wdata     = req_q.wdata;
  assign mem_wmask     = req_q.wmask;
  assign timeout       = timeout_q;
  assign inst_rdata    = mem_rdata;
  assign data_rdata    = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard of expected bus requests and completions.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req, data_we, flush;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wmask;
  logic        mem_req_ready, mem_resp_valid;
  logic [31:0] mem_rdata;

  logic        inst_ready, data_ack, mem_req_valid, mem_we, timeout;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  logic        wd_inst_ready, wd_data_ack, wd_valid, wd_we, wd_timeout;
  logic [31:0] wd_inst_rdata, wd_data_rdata, wd_addr, wd_wdata;
  logic [3:0]  wd_wmask;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(inst_ready), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wmask(data_wmask), .data_ack(data_ack), .data_rdata(data_rdata), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .timeout(timeout)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut_wd (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(wd_inst_ready), .inst_rdata(wd_inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wmask(data_wmask), .data_ack(wd_data_ack), .data_rdata(wd_data_rdata), .flush(flush),
    .mem_req_valid(wd_valid), .mem_req_ready(mem_req_ready), .mem_we(wd_we),
    .mem_addr(wd_addr), .mem_wdata(wd_wdata), .mem_wmask(wd_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .timeout(wd_timeout)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } exp_req_t;
  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
  } exp_rsp_t;

  exp_req_t    exp_req[$];
  exp_rsp_t    exp_rsp[$];
  logic [31:0] rd_q[$];
  int          total = 0;
  int          bad = 0;
  bit          bus_en = 1'b0;
  int          rdy_dly = 0;
  int          resp_dly = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
    exp_req_t e;
    e.we = we; e.addr = a; e.wdata = wd; e.wmask = m;
    exp_req.push_back(e);
  endtask

  task automatic exp_ack(input logic is_data, input logic [31:0] rd);
    exp_rsp_t e;
    e.is_data = is_data; e.rdata = rd;
    exp_rsp.push_back(e);
  endtask

  task automatic wait_done(input bit is_data, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (is_data ? data_ack : inst_ready) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL wait_done: no %s completion within %0d cycles", is_data ? "data" : "inst", budget);
    end
    if (is_data) data_req = 1'b0;
    else         inst_req = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] rd);
    exp_bus(1'b0, a, 32'h0, 4'h0);
    exp_ack(1'b0, rd);
    rd_q.push_back(rd);
    cyc(); inst_addr = a; inst_req = 1'b1;
    wait_done(1'b0, 20);
  endtask

  task automatic do_reset();
    cyc(); reset = 1'b1; bus_en = 1'b0; inst_req = 1'b0; data_req = 1'b0; flush = 1'b0;
    cyc(); cyc(); reset = 1'b0; bus_en = 1'b1;
  endtask

  // Memory bus model: ready after rdy_dly request cycles, response resp_dly cycles into RESP.
  initial begin
    int bphase = 0;
    int wcnt = 0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #2;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      if (!bus_en) begin
        bphase = 0; wcnt = 0;
      end else if (bphase == 0) begin
        if (mem_req_valid) begin
          if (wcnt == rdy_dly) begin mem_req_ready = 1'b1; bphase = 1; wcnt = 0; end
          else wcnt++;
        end
      end else begin
        if (wcnt == resp_dly) begin
          mem_resp_valid = 1'b1;
          mem_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hbad0bad0;
          bphase = 0; wcnt = 0;
        end else wcnt++;
      end
    end
  end

  // Monitor: checks each new bus request, its stability, and every completion pulse.
  initial begin
    exp_req_t cur = '0;
    exp_rsp_t r;
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req_valid) begin
        if (!prev) begin
          if (exp_req.size() == 0) begin
            total++; bad++;
            $display("FAIL req_unexpected: got request addr 0x%0h, required none", mem_addr);
          end else begin
            cur = exp_req.pop_front();
            chk("req_we", mem_we, cur.we);
            chk("req_addr", mem_addr, cur.addr);
            chk("req_wdata", mem_wdata, cur.wdata);
            chk("req_wmask", mem_wmask, cur.wmask);
          end
        end else begin
          chk("req_stable_addr", mem_addr, cur.addr);
          chk("req_stable_fields", {mem_we, mem_wmask, mem_wdata}, {cur.we, cur.wmask, cur.wdata});
        end
      end
      prev = mem_req_valid;
      if (inst_ready || data_ack) begin
        if (exp_rsp.size() == 0) begin
          total++; bad++;
          $display("FAIL ack_unexpected: got inst_ready=%0b data_ack=%0b, required none", inst_ready, data_ack);
        end else begin
          r = exp_rsp.pop_front();
          chk("ack_port", {inst_ready, data_ack}, r.is_data ? 2'b01 : 2'b10);
          chk("ack_rdata", r.is_data ? data_rdata : inst_rdata, r.rdata);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int vcnt, acnt, rcnt, acks;
    reset = 1'b1; inst_req = 1'b0; data_req = 1'b0; flush = 1'b0; data_we = 1'b0;
    inst_addr = '0; data_addr = '0; data_wdata = '0; data_wmask = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; bus_en = 1'b1;

    @(negedge clk);
    chk("rst_ctl", {mem_req_valid, mem_we, mem_wmask, inst_ready, data_ack, timeout}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wd_ctl", {wd_valid, wd_timeout, wd_data_ack, wd_inst_ready}, 0);

    // Single fetch with exact cycle timing
    exp_bus(1'b0, 32'h1c000000, 32'h0, 4'h0);
    exp_ack(1'b0, 32'h02800421);
    rd_q.push_back(32'h02800421);
    cyc(); inst_addr = 32'h1c000000; inst_req = 1'b1;
    @(negedge clk); chk("fetch_c0_valid", mem_req_valid, 0);
    @(negedge clk); chk("fetch_c1_valid", mem_req_valid, 1);
    chk("fetch_c1_addr", mem_addr, 32'h1c000000);
    chk("fetch_c1_ready_early", inst_ready, 0);
    @(negedge clk); chk("fetch_c2_ready", inst_ready, 1);
    chk("fetch_c2_rdata", inst_rdata, 32'h02800421);
    chk("fetch_c2_valid", mem_req_valid, 0);
    inst_req = 1'b0;

    // Store with 3 stalled ready cycles
    rdy_dly = 3;
    exp_bus(1'b1, 32'h100, 32'hdeadbeef, 4'hf);
    exp_ack(1'b1, 32'hcafe0001);
    rd_q.push_back(32'hcafe0001);
    cyc(); data_we = 1'b1; data_addr = 32'h100; data_wdata = 32'hdeadbeef; data_wmask = 4'hf; data_req = 1'b1;
    vcnt = 0; acnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_req_valid) vcnt++;
      if (data_ack) begin acnt++; data_req = 1'b0; end
    end
    chk("store_valid_cycles", vcnt, 4);
    chk("store_ack_pulses", acnt, 1);
    rdy_dly = 0;

    // Conflict alternation from a fresh reset; loads force mask to 0
    do_reset();
    data_we = 1'b0; data_addr = 32'h200; data_wdata = 32'h55aa55aa; data_wmask = 4'hf;
    inst_addr = 32'h1c000040;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) exp_bus(1'b0, 32'h200, 32'h55aa55aa, 4'h0);
      else            exp_bus(1'b0, 32'h1c000040, 32'h0, 4'h0);
      exp_ack(k % 2 == 0, 32'ha0000000 + k);
      rd_q.push_back(32'ha0000000 + k);
    end
    cyc(); inst_req = 1'b1; data_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(negedge clk);
      if (inst_ready || data_ack) acks++;
    end
    inst_req = 1'b0; data_req = 1'b0;
    chk("conflict_acks", acks, 4);

    // Flush during RESP kills the fetch completion
    resp_dly = 2;
    exp_bus(1'b0, 32'h1c000080, 32'h0, 4'h0);
    rd_q.push_back(32'h12345678);
    cyc(); inst_addr = 32'h1c000080; inst_req = 1'b1;
    cyc();
    cyc(); flush = 1'b1; inst_req = 1'b0;
    cyc(); flush = 1'b0;
    rcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (inst_ready) rcnt++;
    end
    chk("kill_no_ready", rcnt, 0);
    chk("kill_bus_completed", rd_q.size(), 0);
    resp_dly = 0;
    fetch(32'h1c000084, 32'h00112233);

    // Flush on the response cycle also suppresses inst_ready
    exp_bus(1'b0, 32'h1c000090, 32'h0, 4'h0);
    rd_q.push_back(32'h77777777);
    cyc(); inst_addr = 32'h1c000090; inst_req = 1'b1;
    cyc();
    cyc(); flush = 1'b1; inst_req = 1'b0;
    @(negedge clk);
    chk("flush_on_resp_ready", inst_ready, 0);
    chk("flush_on_resp_seen", mem_resp_valid, 1);
    cyc(); flush = 1'b0;

    // Flush does not touch a data access; dropping data_req mid-flight still acks
    exp_bus(1'b0, 32'h300, 32'h0, 4'h0);
    exp_ack(1'b1, 32'h0badf00d);
    rd_q.push_back(32'h0badf00d);
    cyc(); data_we = 1'b0; data_addr = 32'h300; data_wdata = 32'h0; data_wmask = 4'h3;
    data_req = 1'b1; flush = 1'b1;
    cyc(); data_req = 1'b0;
    wait_done(1'b1, 20);
    flush = 1'b0;

    // Watchdog on the TIMEOUT=4 instance with the bus never ready
    do_reset();
    bus_en = 1'b0;
    exp_bus(1'b1, 32'h400, 32'h11112222, 4'h3);
    cyc(); data_we = 1'b1; data_addr = 32'h400; data_wdata = 32'h11112222; data_wmask = 4'h3; data_req = 1'b1;
    acnt = 0;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("wd_c%0d_valid", c), wd_valid, (c >= 1 && c <= 4) ? 1 : 0);
      chk($sformatf("wd_c%0d_timeout", c), wd_timeout, (c >= 5) ? 1 : 0);
      if (wd_data_ack || wd_inst_ready) acnt++;
      if (c == 4) data_req = 1'b0;
    end
    chk("wd_no_ack", acnt, 0);
    chk("main_no_timeout", timeout, 0);
    do_reset();
    @(negedge clk);
    chk("wd_timeout_cleared", wd_timeout, 0);

    // Reset while waiting for a response
    resp_dly = 5;
    exp_bus(1'b0, 32'h1c000100, 32'h0, 4'h0);
    cyc(); inst_addr = 32'h1c000100; inst_req = 1'b1;
    cyc();
    cyc();
    cyc(); reset = 1'b1; bus_en = 1'b0; inst_req = 1'b0;
    cyc();
    @(negedge clk);
    chk("rstmid_ctl", {mem_req_valid, mem_we, mem_wmask, inst_ready, data_ack, timeout}, 0);
    chk("rstmid_addr", mem_addr, 0);
    chk("rstmid_wdata", mem_wdata, 0);
    cyc(); reset = 1'b0; bus_en = 1'b1; resp_dly = 0;
    fetch(32'h1c000104, 32'h89abcdef);

    repeat (3) @(negedge clk);
    chk("sb_req_left", exp_req.size(), 0);
    chk("sb_rsp_left", exp_rsp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
